// File: rtl/seg7_pkg.sv
// Shared definitions for the match-count display path: FSM state encoding,
// decimal range helper and default BCD field width.
// Latency: n/a (package). Backpressure: n/a.
package seg7_pkg;

    localparam int DIGITS_DEF = 4;
    localparam int BCD_W      = 4 * DIGITS_DEF;

    // Converter FSM states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] max_dec(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: digits of 5 or more get +3
// so the following left shift carries correctly into the next digit.
// Latency: combinational. Backpressure: none.
// Ports: digit_in - nibble before correction; digit_out - corrected nibble.
module bcd_digit_adj
    import seg7_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_serial.sv
// Iterative shift-add-3 binary-to-BCD converter, one conversion per start.
// Latency: start at edge k -> done visible after edge k+BIN_W+1; one result per BIN_W+2 cycles.
// Backpressure: start is ignored while busy (not queued); results held until the next done.
// Ports: clock_100Mhz/reset (sync, active-low); start/bin_in request; busy, done pulse,
//        bcd_out (digit 0 in [3:0]) and overflow (saturated to all-9s) results.
module bin2bcd_serial
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int          BW      = 4 * DIGITS;
    localparam int          SCR_W   = BIN_W + BW;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_DEC = max_dec(DIGITS);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic             ovf_r_q, ovf_r_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    // Corrected BCD field, and the scratch word with that field substituted.
    logic [BW-1:0]    adj_bcd;
    logic [SCR_W-1:0] adj_scratch;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[BIN_W + 4*g +: 4]),
            .digit_out (adj_bcd[4*g +: 4])
        );
    end

    assign adj_scratch = {adj_bcd, scratch_q[BIN_W-1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        ovf_r_d    = ovf_r_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    scratch_d = {{BW{1'b0}}, bin_in};
                    cnt_d     = CNT_W'(BIN_W);
                    ovf_r_d   = ({{(64-BIN_W){1'b0}}, bin_in} > MAX_DEC);
                end
            end
            ST_SHIFT: begin
                // Carries out of the top nibble fall off the shift; the
                // overflow flag captured at accept covers that case.
                scratch_d = {adj_scratch[SCR_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                overflow_d = ovf_r_q;
                bcd_d      = ovf_r_q ? {DIGITS{4'h9}} : scratch_q[SCR_W-1:BIN_W];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            scratch_q  <= '0;
            ovf_r_q    <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            ovf_r_q    <= ovf_r_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
module tb_bin2bcd_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int total;
    int bad;

    bin2bcd_serial #(.BIN_W(16), .DIGITS(4)) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .start        (start),
        .bin_in       (bin_in),
        .busy         (busy),
        .done         (done),
        .bcd_out      (bcd_out),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and wait (bounded) for done. lat = edges after the
    // accepting edge until done is seen, -1 if it never came.
    task automatic convert(input logic [15:0] v, output int lat, output logic busy_seen);
        bin_in = v;
        start  = 1'b1;
        tick();
        start     = 1'b0;
        busy_seen = busy;
        lat       = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = 16'd0;
        tick(); tick(); tick();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (bcd_out !== 16'h0)  begin bad++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int   lat;
        logic b;
        convert(16'd0, lat, b);
        total++; if (b !== 1'b1)          begin bad++; $display("FAIL zero_busy: got %b want 1", b); end
        total++; if (lat !== 17)          begin bad++; $display("FAIL zero_latency: got %0d want 17", lat); end
        total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL zero_bcd: got %h want 0000", bcd_out); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL zero_ovf: got %b want 0", overflow); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
        tick();
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_values();
        logic [15:0] vin [4];
        logic [15:0] vexp[4];
        logic        oexp[4];
        int   lat;
        logic b;
        vin[0] = 16'd1234;  vexp[0] = 16'h1234; oexp[0] = 1'b0;
        vin[1] = 16'd9999;  vexp[1] = 16'h9999; oexp[1] = 1'b0;
        vin[2] = 16'd10000; vexp[2] = 16'h9999; oexp[2] = 1'b1;
        vin[3] = 16'hFFFF;  vexp[3] = 16'h9999; oexp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            convert(vin[i], lat, b);
            total++; if (lat !== 17)
                begin bad++; $display("FAIL val_latency[%0d]: got %0d want 17", vin[i], lat); end
            total++; if (bcd_out !== vexp[i])
                begin bad++; $display("FAIL val_bcd[%0d]: got %h want %h", vin[i], bcd_out, vexp[i]); end
            total++; if (overflow !== oexp[i])
                begin bad++; $display("FAIL val_ovf[%0d]: got %b want %b", vin[i], overflow, oexp[i]); end
            // bin_in wandering after done must not disturb the held result.
            bin_in = 16'd4321;
            tick(); tick();
            total++; if (bcd_out !== vexp[i])
                begin bad++; $display("FAIL val_hold[%0d]: got %h want %h", vin[i], bcd_out, vexp[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int          ndone;
        logic [15:0] seen;
        ndone  = 0;
        seen   = 16'h0;
        bin_in = 16'd42;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bin_in = 16'd77;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = 16'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                seen = bcd_out;
            end
        end
        total++; if (ndone !== 1)      begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        total++; if (seen !== 16'h0042) begin bad++; $display("FAIL ignore_bcd: got %h want 0042", seen); end
    endtask

    task automatic test_mid_reset();
        int   ndone;
        int   lat;
        logic b;
        ndone  = 0;
        bin_in = 16'd5678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mreset_busy: got %b want 0", busy); end
        total++; if (bcd_out !== 16'h0) begin bad++; $display("FAIL mreset_bcd: got %h want 0000", bcd_out); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL mreset_done: got %b want 0", done); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        total++; if (ndone !== 0)       begin bad++; $display("FAIL mreset_stray_done: got %0d want 0", ndone); end
        convert(16'd5678, lat, b);
        total++; if (lat !== 17)        begin bad++; $display("FAIL mreset_latency: got %0d want 17", lat); end
        total++; if (bcd_out !== 16'h5678) begin bad++; $display("FAIL mreset_bcd_after: got %h want 5678", bcd_out); end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          last;
        int          k;
        logic        chk_busy;
        logic [15:0] exp_bcd;
        cyc      = 0;
        last     = -1;
        k        = 0;
        chk_busy = 1'b0;
        bin_in   = 16'd1;
        start    = 1'b1;
        for (int n = 0; n < 100 && k < 3; n++) begin
            tick();
            cyc++;
            if (chk_busy) begin
                chk_busy = 1'b0;
                total++; if (busy !== 1'b1)
                    begin bad++; $display("FAIL b2b_busy_back[%0d]: got %b want 1", k, busy); end
            end
            if (done === 1'b1) begin
                exp_bcd = 16'(k + 1);
                total++; if (bcd_out !== exp_bcd)
                    begin bad++; $display("FAIL b2b_bcd[%0d]: got %h want %h", k, bcd_out, exp_bcd); end
                total++; if (busy !== 1'b0)
                    begin bad++; $display("FAIL b2b_busy_gap[%0d]: got %b want 0", k, busy); end
                if (last >= 0) begin
                    total++; if (cyc - last !== 18)
                        begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 18", k, cyc - last); end
                end
                last   = cyc;
                k++;
                bin_in = 16'(k + 1);
                if (k == 3) start = 1'b0;
                else        chk_busy = 1'b1;
            end
        end
        start = 1'b0;
        total++; if (k !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", k); end
        tick(); tick(); tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_values();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
